// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the five-stage pipeline: load-use and MDU stalls,
// control-flow flushes, and saturating stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int REG_COUNT   = 32,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_WIDTH   = 32,
    localparam int RW         = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_ex_mem_read,
    input  logic [RW-1:0]        id_ex_rd,
    input  logic [RW-1:0]        if_id_rs1,
    input  logic [RW-1:0]        if_id_rs2,
    input  logic                 if_id_rs1_used,
    input  logic                 if_id_rs2_used,
    input  logic                 id_is_mdu,
    input  logic                 ex_mdu_start,
    input  logic [RW-1:0]        ex_mdu_rd,
    input  logic                 branch_taken,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic                 cnt_clear,
    output logic                 stall,
    output logic                 flush,
    output logic                 mdu_busy,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_cycles
);

    localparam logic [7:0]           LAT     = 8'(MDU_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [7:0]           mdu_cnt_q, mdu_cnt_d;
    logic [RW-1:0]        pend_rd_q, pend_rd_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic busy;
    logic load_hz;
    logic mdu_raw;
    logic mdu_struct;
    logic flush_req;

    // x0 is hardwired zero, so it never carries a dependency
    function automatic logic src_match(input logic [RW-1:0] r,
                                       input logic [RW-1:0] rs1,
                                       input logic          rs1_used,
                                       input logic [RW-1:0] rs2,
                                       input logic          rs2_used);
        logic m1;
        logic m2;
        m1 = rs1_used && (rs1 == r) && (r != '0);
        m2 = rs2_used && (rs2 == r) && (r != '0);
        return m1 || m2;
    endfunction

    always_comb begin
        busy = (mdu_cnt_q != 8'd0);

        load_hz = id_ex_mem_read
            && src_match(id_ex_rd, if_id_rs1, if_id_rs1_used,
                         if_id_rs2, if_id_rs2_used);

        mdu_raw = (ex_mdu_start
            && src_match(ex_mdu_rd, if_id_rs1, if_id_rs1_used,
                         if_id_rs2, if_id_rs2_used))
            || (busy
            && src_match(pend_rd_q, if_id_rs1, if_id_rs1_used,
                         if_id_rs2, if_id_rs2_used));

        mdu_struct = id_is_mdu && (ex_mdu_start || busy);
        flush_req  = branch_taken || is_jal || is_jalr;

        // The ID instruction is wrong-path on a flush, so it is never stalled
        flush = flush_req;
        stall = !flush_req && (load_hz || mdu_raw || mdu_struct);
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        pend_rd_d = pend_rd_q;
        if (ex_mdu_start) begin
            mdu_cnt_d = LAT;
            pend_rd_d = ex_mdu_rd;
        end else if (busy) begin
            mdu_cnt_d = mdu_cnt_q - 8'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_cnt_q   <= 8'd0;
            pend_rd_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            pend_rd_q   <= pend_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mdu_busy     = busy;
    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit, with a second 4-bit
// counter instance sharing the same stimulus to exercise saturation.
module tb_hazard_ctrl_unit;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_ex_mem_read;
    logic [RW-1:0] id_ex_rd;
    logic [RW-1:0] if_id_rs1;
    logic [RW-1:0] if_id_rs2;
    logic          if_id_rs1_used;
    logic          if_id_rs2_used;
    logic          id_is_mdu;
    logic          ex_mdu_start;
    logic [RW-1:0] ex_mdu_rd;
    logic          branch_taken;
    logic          is_jal;
    logic          is_jalr;
    logic          cnt_clear;

    logic          stall, flush, mdu_busy;
    logic [31:0]   stall_cycles, flush_cycles;
    logic          stall4, flush4, mdu_busy4;
    logic [3:0]    stall_cycles4, flush_cycles4;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_COUNT(32), .MDU_LATENCY(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
        .id_is_mdu(id_is_mdu), .ex_mdu_start(ex_mdu_start),
        .ex_mdu_rd(ex_mdu_rd), .branch_taken(branch_taken),
        .is_jal(is_jal), .is_jalr(is_jalr), .cnt_clear(cnt_clear),
        .stall(stall), .flush(flush), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    hazard_ctrl_unit #(.REG_COUNT(32), .MDU_LATENCY(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
        .id_is_mdu(id_is_mdu), .ex_mdu_start(ex_mdu_start),
        .ex_mdu_rd(ex_mdu_rd), .branch_taken(branch_taken),
        .is_jal(is_jal), .is_jalr(is_jalr), .cnt_clear(cnt_clear),
        .stall(stall4), .flush(flush4), .mdu_busy(mdu_busy4),
        .stall_cycles(stall_cycles4), .flush_cycles(flush_cycles4)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        busy;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference state of the pipeline hazard model
    logic [7:0]    m_cnt;
    logic [RW-1:0] m_pend;
    logic [31:0]   m_sc, m_fc;
    logic [3:0]    m_sc4, m_fc4;
    logic          e_stall, e_flush;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_match(input logic [RW-1:0] r);
        return (if_id_rs1_used && if_id_rs1 == r && r != 0)
            || (if_id_rs2_used && if_id_rs2 == r && r != 0);
    endfunction

    task automatic step();
        exp_t e;
        exp_t o;
        logic lh, raw, st, fr;
        if (rst) begin
            m_cnt  = 0;
            m_pend = 0;
            m_sc   = 0;
            m_fc   = 0;
            m_sc4  = 0;
            m_fc4  = 0;
        end
        lh  = id_ex_mem_read && m_match(id_ex_rd);
        raw = (ex_mdu_start && m_match(ex_mdu_rd))
            || (m_cnt != 0 && m_match(m_pend));
        st  = id_is_mdu && (ex_mdu_start || m_cnt != 0);
        fr  = branch_taken || is_jal || is_jalr;
        e_flush = fr;
        e_stall = !fr && (lh || raw || st);
        e.stall = e_stall;
        e.flush = e_flush;
        e.busy  = (m_cnt != 0);
        e.sc    = m_sc;
        e.fc    = m_fc;
        e.sc4   = m_sc4;
        e.fc4   = m_fc4;
        exp_q.push_back(e);
        #1;
        o = exp_q.pop_front();
        chk("stall", 32'(stall), 32'(o.stall));
        chk("flush", 32'(flush), 32'(o.flush));
        chk("mdu_busy", 32'(mdu_busy), 32'(o.busy));
        chk("stall_cycles", stall_cycles, o.sc);
        chk("flush_cycles", flush_cycles, o.fc);
        chk("stall_cycles4", 32'(stall_cycles4), 32'(o.sc4));
        chk("flush_cycles4", 32'(flush_cycles4), 32'(o.fc4));
        if (ex_mdu_start) begin
            chk("start_while_busy", 32'(mdu_busy), 32'd0);
        end
        @(posedge clk);
        if (!rst) begin
            if (ex_mdu_start) begin
                m_cnt  = 8'd4;
                m_pend = ex_mdu_rd;
            end else if (m_cnt != 0) begin
                m_cnt = m_cnt - 8'd1;
            end
            if (cnt_clear) begin
                m_sc  = 0;
                m_fc  = 0;
                m_sc4 = 0;
                m_fc4 = 0;
            end else begin
                if (e_stall && m_sc != 32'hffff_ffff) m_sc = m_sc + 1;
                if (e_flush && m_fc != 32'hffff_ffff) m_fc = m_fc + 1;
                if (e_stall && m_sc4 != 4'hf) m_sc4 = m_sc4 + 1;
                if (e_flush && m_fc4 != 4'hf) m_fc4 = m_fc4 + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_ex_mem_read = 0;
        id_ex_rd       = 0;
        if_id_rs1      = 0;
        if_id_rs2      = 0;
        if_id_rs1_used = 0;
        if_id_rs2_used = 0;
        id_is_mdu      = 0;
        ex_mdu_start   = 0;
        ex_mdu_rd      = 0;
        branch_taken   = 0;
        is_jal         = 0;
        is_jalr        = 0;
        cnt_clear      = 0;
    endtask

    initial begin
        m_cnt = 0; m_pend = 0; m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        e_stall = 0; e_flush = 0;
        idle();
        rst = 1;
        @(negedge clk);
        step();
        step();
        rst = 0;
        step();

        // Load-use with used qualification and x0
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_rs2_used = 1;
        step();
        chk("load_use_stall", 32'(stall), 32'd1);
        if_id_rs2_used = 0;
        step();
        id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
        if_id_rs1_used = 1; if_id_rs2_used = 1;
        step();
        idle();
        step();

        // MDU RAW on x7
        ex_mdu_start = 1; ex_mdu_rd = 7; if_id_rs1 = 7; if_id_rs1_used = 1;
        step();
        ex_mdu_start = 0;
        for (int i = 0; i < 6; i++) step();
        idle();

        // Structural hazard
        ex_mdu_start = 1; ex_mdu_rd = 9;
        step();
        ex_mdu_start = 0; id_is_mdu = 1; if_id_rs1 = 3; if_id_rs1_used = 1;
        for (int i = 0; i < 5; i++) step();
        idle();

        // Flush priority, and flush leaves MDU countdown intact
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_rs2_used = 1;
        branch_taken = 1;
        step();
        idle();
        ex_mdu_start = 1; ex_mdu_rd = 10;
        step();
        ex_mdu_start = 0; is_jalr = 1;
        step();
        step();
        is_jalr = 0;
        for (int i = 0; i < 3; i++) step();

        // Counters
        cnt_clear = 1;
        step();
        cnt_clear = 0;
        id_ex_mem_read = 1; id_ex_rd = 6; if_id_rs1 = 6; if_id_rs1_used = 1;
        for (int i = 0; i < 3; i++) step();
        idle();
        branch_taken = 1;
        for (int i = 0; i < 2; i++) step();
        idle();
        step();
        chk("stall_cnt_3", stall_cycles, 32'd3);
        chk("flush_cnt_2", flush_cycles, 32'd2);
        cnt_clear = 1;
        step();
        cnt_clear = 0;
        step();
        chk("stall_cnt_clr", stall_cycles, 32'd0);
        chk("flush_cnt_clr", flush_cycles, 32'd0);
        id_ex_mem_read = 1; id_ex_rd = 6; if_id_rs1 = 6; if_id_rs1_used = 1;
        for (int i = 0; i < 20; i++) step();
        idle();
        step();
        chk("stall_cnt_20", stall_cycles, 32'd20);
        chk("stall_cnt4_sat", 32'(stall_cycles4), 32'd15);

        // Reset in the middle of an MDU op
        ex_mdu_start = 1; ex_mdu_rd = 12;
        step();
        ex_mdu_start = 0;
        step();
        if_id_rs1 = 12; if_id_rs1_used = 1;
        rst = 1;
        step();
        chk("rst_busy_clear", 32'(mdu_busy), 32'd0);
        rst = 0;
        step();
        chk("post_rst_no_stall", 32'(stall), 32'd0);
        idle();
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
